// File: rtl/fifo_uart_tx_pkg.sv
// Shared encodings, defaults and small helpers for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

    // Default baud divider for a 50 MHz clock at 115200 baud.
    localparam int unsigned DefaultClksPerBit = 434;

    // Payload width of one 8N1 frame.
    localparam int unsigned DataBits = 8;

    // Index of the last data bit within a frame.
    localparam logic [2:0] LastBitIdx = 3'(DataBits - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPop   = 3'd1,
        StLatch = 3'd2,
        StStart = 3'd3,
        StData  = 3'd4,
        StStop  = 3'd5
    } tx_state_e;

    // A frame owns the line from the pop request through its last stop cycle.
    function automatic logic state_is_active(input tx_state_e st);
        return st != StIdle;
    endfunction

    // Serial line level for a state; data bits come from the shift register LSB.
    function automatic logic line_level(input tx_state_e st, input logic data_bit);
        logic level;
        case (st)
            StStart: level = 1'b0;
            StData:  level = data_bit;
            default: level = 1'b1;
        endcase
        return level;
    endfunction

    // States whose duration is one baud period (or one per data bit).
    function automatic logic state_is_timed(input tx_state_e st);
        return (st == StStart) || (st == StData) || (st == StStop);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_counter.sv
// Baud-period counter: counts 0..CLKS_PER_BIT-1 and holds at the terminal value.
module baud_counter
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] TermCount = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] count_q;

    assign terminal = (count_q == TermCount);

    // Clear wins over enable; the count never wraps past the terminal value.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !terminal) begin
            count_q <= count_q + CntW'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that pulls bytes from an upstream FIFO, one pop per frame.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    input  logic       fifo_busy,
    output logic       fifo_pop,
    output logic       tx,
    output logic       tx_active,
    output logic       tx_done
);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;

    logic baud_clear;
    logic baud_enable;
    logic baud_term;

    logic tx_d;
    logic pop_d;
    logic active_d;
    logic done_d;

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_counter (
        .clock   (clock),
        .reset   (reset),
        .clear   (baud_clear),
        .enable  (baud_enable),
        .terminal(baud_term)
    );

    // Next-state logic; the counter restarts on every state entry and every data bit.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        done_d      = 1'b0;
        baud_enable = state_is_timed(state_q);
        baud_clear  = !state_is_timed(state_q) || baud_term;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !fifo_busy) begin
                    state_d = StPop;
                end
            end
            StPop: begin
                state_d = StLatch;
            end
            StLatch: begin
                // The upstream FIFO presents the popped byte during this cycle.
                shift_d = fifo_data;
                state_d = StStart;
            end
            StStart: begin
                if (baud_term) begin
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                end
            end
            StData: begin
                if (baud_term) begin
                    if (bit_idx_q == LastBitIdx) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            StStop: begin
                if (baud_term) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        tx_d     = line_level(state_d, shift_d[0]);
        pop_d    = (state_d == StPop);
        active_d = state_is_active(state_d);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx        <= 1'b1;
            fifo_pop  <= 1'b0;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx        <= tx_d;
            fifo_pop  <= pop_d;
            tx_active <= active_d;
            tx_done   <= done_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a 4-clock bit period and a small FIFO model.
module tb_fifo_uart_tx;

    localparam int unsigned Clks = 4;

    logic       clock;
    logic       reset;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_busy;
    logic       fifo_pop;
    logic       tx;
    logic       tx_active;
    logic       tx_done;

    int n_checks   = 0;
    int n_fail     = 0;
    int cycle      = 0;
    int pop_count  = 0;
    int done_count = 0;

    logic [7:0] fifo_q[$];

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [9:0] frame;  // frame[0] is the start bit, frame[9] the stop bit
    } vec_t;

    vec_t vecs[4];

    fifo_uart_tx #(
        .CLKS_PER_BIT(Clks)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_busy (fifo_busy),
        .fifo_pop  (fifo_pop),
        .tx        (tx),
        .tx_active (tx_active),
        .tx_done   (tx_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; samples 1 time unit after the edge and services the FIFO model.
    task automatic tick();
        @(posedge clock);
        #1;
        cycle++;
        if (fifo_pop === 1'b1) begin
            pop_count++;
            if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
            fifo_empty = (fifo_q.size() == 0);
        end
        if (tx_done === 1'b1) done_count++;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_pop(input string name, input int exp_lat);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (fifo_pop !== 1'b1 && n < 200);
        check({name, " pop_latency"}, n, exp_lat);
    endtask

    // Called at the POP-cycle sample point; ends at the tx_done IDLE cycle.
    task automatic check_frame(input string name, input logic [9:0] frame);
        logic [3:0] s;
        logic       bad_ctl;
        bad_ctl = 1'b0;
        tick();
        check({name, " latch_tx"}, tx, 1);
        check({name, " latch_pop"}, fifo_pop, 0);
        check({name, " latch_active"}, tx_active, 1);
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                s[c] = tx;
                if (fifo_pop !== 1'b0 || tx_active !== 1'b1 || tx_done !== 1'b0) bad_ctl = 1'b1;
            end
            check($sformatf("%s bit%0d", name, k), s, {4{frame[k]}});
        end
        check({name, " ctl_during_frame"}, bad_ctl, 0);
        tick();
        check({name, " done_pulse"}, tx_done, 1);
        check({name, " done_active"}, tx_active, 0);
        check({name, " done_tx"}, tx, 1);
    endtask

    initial begin
        int p;
        int d;
        int c1;
        logic bad_tx;
        logic bad_act;

        vecs[0] = '{"byte_f1", 8'hF1, 10'b1111100010};
        vecs[1] = '{"byte_00", 8'h00, 10'b1000000000};
        vecs[2] = '{"byte_ff", 8'hFF, 10'b1111111110};
        vecs[3] = '{"byte_55", 8'h55, 10'b1010101010};

        reset      = 1'b0;
        fifo_empty = 1'b0;
        fifo_busy  = 1'b0;
        fifo_data  = 8'hF1;

        // Held in reset with data available: nothing may move.
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("reset%0d tx", i), tx, 1);
            check($sformatf("reset%0d pop", i), fifo_pop, 0);
            check($sformatf("reset%0d active", i), tx_active, 0);
            check($sformatf("reset%0d done", i), tx_done, 0);
        end
        fifo_empty = 1'b1;
        reset      = 1'b1;
        tick();
        check("idle_after_reset pop", fifo_pop, 0);
        check("idle_after_reset pop_count", pop_count, 0);

        // Single-frame table.
        for (int i = 0; i < 4; i++) begin
            p = pop_count;
            d = done_count;
            push(vecs[i].data);
            wait_pop(vecs[i].name, 1);
            check_frame(vecs[i].name, vecs[i].frame);
            check({vecs[i].name, " pops"}, pop_count - p, 1);
            check({vecs[i].name, " dones"}, done_count - d, 1);
        end

        // Back-to-back frames: pop in the same IDLE cycle that carries tx_done.
        p = pop_count;
        push(8'hFA);
        push(8'h91);
        wait_pop("b2b_first", 1);
        c1 = cycle;
        check_frame("b2b_fa", 10'b1111110100);
        wait_pop("b2b_second", 1);
        check("b2b_pop_spacing", cycle - c1, 43);
        check_frame("b2b_91", 10'b1100100010);
        check("b2b_pops", pop_count - p, 2);

        // Busy upstream holds off the pop.
        fifo_busy = 1'b1;
        p = pop_count;
        bad_act = 1'b0;
        push(8'h3C);
        repeat (20) begin
            tick();
            if (tx_active !== 1'b0) bad_act = 1'b1;
        end
        check("busy pops", pop_count - p, 0);
        check("busy active", bad_act, 0);
        fifo_busy = 1'b0;
        wait_pop("busy_release", 1);
        check_frame("byte_3c", 10'b1001111000);

        // Reset during data bit 3 of 0xF1 aborts the frame.
        d = done_count;
        push(8'hF1);
        wait_pop("abort", 1);
        repeat (19) tick();
        check("abort bit3_tx", tx, 0);
        push(8'h00);
        fifo_data = 8'hAA;
        reset = 1'b0;
        p = pop_count;
        tick();
        check("abort tx", tx, 1);
        check("abort active", tx_active, 0);
        check("abort pop", fifo_pop, 0);
        check("abort done", tx_done, 0);
        repeat (5) tick();
        check("abort pops_in_reset", pop_count - p, 0);
        check("abort no_done", done_count - d, 0);
        reset = 1'b1;
        wait_pop("after_abort", 1);
        check_frame("after_abort_00", 10'b1000000000);
        check("after_abort dones", done_count - d, 1);

        // Long empty stretch with a wiggling data bus.
        p = pop_count;
        bad_tx = 1'b0;
        bad_act = 1'b0;
        repeat (1000) begin
            fifo_data = 8'($urandom);
            tick();
            if (tx !== 1'b1) bad_tx = 1'b1;
            if (tx_active !== 1'b0) bad_act = 1'b1;
        end
        check("empty pops", pop_count - p, 0);
        check("empty tx", bad_tx, 0);
        check("empty active", bad_act, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
